// File: rtl/axi_pkg.sv
// Shared AXI3 encodings and client IDs for the CPU-side AXI initiators.
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [2:0] SIZE_1B = 3'b000;
   localparam logic [2:0] SIZE_2B = 3'b001;
   localparam logic [2:0] SIZE_4B = 3'b010;

   localparam logic [1:0] LOCK_NORMAL    = 2'b00;
   localparam logic [1:0] LOCK_EXCLUSIVE = 2'b01;
   localparam logic [1:0] LOCK_LOCKED    = 2'b10;

   localparam logic [3:0] ID_STORE = 4'b0010;
   localparam logic [3:0] ID_LOAD  = 4'b0011;

   typedef enum logic [1:0] {
      LD_BYTE = 2'd0,
      LD_HALF = 2'd1,
      LD_WORD = 2'd2,
      LD_RSVD = 2'd3
   } load_size_e;

endpackage

// File: rtl/load_extend.sv
// Lane select and sign/zero extension of a 32-bit read word for CPU loads.
module load_extend
   import axi_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [1:0]  size,
   input  logic        is_signed,
   output logic [31:0] out
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = rdata[7:0];
      case (addr)
         2'd0: byte_lane = rdata[7:0];
         2'd1: byte_lane = rdata[15:8];
         2'd2: byte_lane = rdata[23:16];
         2'd3: byte_lane = rdata[31:24];
         default: byte_lane = rdata[7:0];
      endcase
   end

   assign half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

   // The reserved size code falls through to a full word.
   always_comb begin
      out = rdata;
      case (load_size_e'(size))
         LD_BYTE: out = {{24{is_signed & byte_lane[7]}}, byte_lane};
         LD_HALF: out = {{16{is_signed & half_lane[15]}}, half_lane};
         default: out = rdata;
      endcase
   end

endmodule

// File: rtl/uncached_loader.sv
// Single-beat AXI3 read initiator for uncached CPU loads in the MEM stage.
//
//   state     | meaning
//   IDLE      | no access; samples need_read
//   WAIT_GRNT | req high, waiting for the shared-port grant
//   ADDR      | arvalid high until arready
//   DATA      | rready high until the load-ID last beat arrives
//   DONE      | result in cpu_rdata, stall released, req dropped next edge
module uncached_loader
   import axi_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   output logic        req,
   input  logic        grnt,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   input  logic        cpu_uncached,
   input  logic        cpu_re,
   input  logic [31:0] cpu_addr,
   input  logic [1:0]  cpu_size,
   input  logic        cpu_signed,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   output logic        cpu_pc_stall
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_GRNT = 3'd1,
      S_ADDR      = 3'd2,
      S_DATA      = 3'd3,
      S_DONE      = 3'd4
   } state_e;

   state_e      state;
   logic        need_read;
   logic        beat_ok;
   logic [31:0] load_data;
   logic        unused_rresp;

   // Error responses complete the access like OKAY, so rresp has no consumer.
   assign unused_rresp = ^rresp;

   assign need_read = cpu_uncached & cpu_re;
   assign beat_ok   = rvalid & rlast & (rid == ID_LOAD);

   assign arid    = ID_LOAD;
   assign araddr  = cpu_addr;
   assign arlen   = 4'b0000;
   assign arsize  = {1'b0, cpu_size};
   assign arburst = BURST_INCR;
   assign arlock  = LOCK_NORMAL;
   assign arcache = 4'b0000;
   assign arprot  = 3'b000;

   assign cpu_stall    = ~(((state == S_IDLE) & ~need_read) | (state == S_DONE));
   assign cpu_pc_stall = cpu_stall;

   load_extend u_extend (
      .rdata     (rdata),
      .addr      (cpu_addr[1:0]),
      .size      (cpu_size),
      .is_signed (cpu_signed),
      .out       (load_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         req       <= 1'b0;
         arvalid   <= 1'b0;
         rready    <= 1'b0;
         cpu_rdata <= 32'h0;
      end else begin
         case (state)
            S_IDLE: begin
               arvalid <= 1'b0;
               rready  <= 1'b0;
               if (need_read) begin
                  state <= S_WAIT_GRNT;
                  req   <= 1'b1;
               end else begin
                  req <= 1'b0;
               end
            end
            S_WAIT_GRNT: begin
               if (grnt) begin
                  state   <= S_ADDR;
                  arvalid <= 1'b1;
               end
            end
            S_ADDR: begin
               if (arready) begin
                  state   <= S_DATA;
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
               end
            end
            S_DATA: begin
               if (beat_ok) begin
                  state     <= S_DONE;
                  cpu_rdata <= load_data;
                  rready    <= 1'b0;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               req   <= 1'b0;
            end
            default: begin
               state     <= S_IDLE;
               req       <= 1'b0;
               arvalid   <= 1'b0;
               rready    <= 1'b0;
               cpu_rdata <= 32'h0;
            end
         endcase
      end
   end

endmodule

// File: doc/uncached_loader.md
# uncached_loader

AXI3 single-beat read initiator for uncached CPU loads in the MEM stage; the read-side counterpart of the uncached store path. Requests the shared AXI port from the arbiter, issues one read address, captures the one data beat, and returns a lane-aligned, sign- or zero-extended result. Stalls the pipeline and PC from detection until the data is available.

## Interface
- ARID, 4'b0011, fixed AR transaction ID; the block accepts R beats only with this ID.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req  out  1  arbiter request; held from the cycle after detection through DONE
- grnt  in  1  arbiter grant
- arid  out  4  = ARID
- araddr  out  32  = cpu_addr, unmodified
- arlen  out  4  4'b0000
- arsize  out  3  {1'b0, cpu_size}
- arburst  out  2  2'b01 (INCR)
- arlock  out  2  2'b00
- arcache  out  4  4'b0000
- arprot  out  3  3'b000
- arvalid  out  1  address valid
- arready  in  1  address ready
- rid  in  4  read ID
- rdata  in  32  read data
- rresp  in  2  read response; ignored
- rlast  in  1  last beat
- rvalid  in  1  data valid
- rready  out  1  data ready; registered
- cpu_uncached  in  1  access is uncached
- cpu_re  in  1  access is a load
- cpu_addr  in  32  byte address; naturally aligned by the CPU
- cpu_size  in  2  0 = byte, 1 = half, 2 = word
- cpu_signed  in  1  1 = sign-extend, 0 = zero-extend
- cpu_rdata  out  32  extended load result; holds its value until the next capture
- cpu_stall  out  1  pipeline stall
- cpu_pc_stall  out  1  identical to cpu_stall

## Operation
- need_read = cpu_uncached & cpu_re.
- States are IDLE, WAIT_GRNT, ADDR, DATA and DONE.
  - IDLE: if need_read, go to WAIT_GRNT and set req to 1. Otherwise stay in IDLE with req, arvalid and rready all 0.
  - WAIT_GRNT: on grnt, go to ADDR and set arvalid to 1.
  - ADDR: hold arvalid until arready is sampled 1. Then go to DATA, set arvalid to 0 and rready to 1.
  - DATA: on rvalid & rlast & (rid == ARID), latch the extended data into cpu_rdata, set rready to 0 and go to DONE. Beats with a different rid are ignored and rready stays 1.
  - DONE: unconditionally go to IDLE and set req to 0.
- cpu_stall = ~((IDLE & ~need_read) | DONE). It is combinational, so it asserts in the detection cycle.
- Extension uses lane = cpu_addr[1:0].
  - byte: rdata[8*lane +: 8], extended to 32 bits.
  - half: rdata[16*cpu_addr[1] +: 16], extended to 32 bits.
  - word: rdata unchanged.
- The AR address and control outputs are combinational from the cpu_* inputs. The CPU holds the cpu_* inputs stable while cpu_stall = 1.
- A non-OKAY rresp still completes the access and returns rdata.
- cpu_size = 3 is treated as word.
- An unused state encoding returns to IDLE with all registered outputs set to 0.

## Timing
- Reset values are all 0: req, arvalid, rready, cpu_rdata. The state is IDLE.
- Reset mid-transaction forces the reset values on the next edge. No AXI cleanup is performed; the interconnect is reset on the same rst_n.
- Minimum latency with grnt, arready and rvalid all immediate:
  - cycle 0: detection, cpu_stall = 1.
  - cycle 1: WAIT_GRNT, req = 1.
  - cycle 2: ADDR, arvalid = 1.
  - cycle 3: DATA, rready = 1.
  - cycle 4: DONE, cpu_stall = 0, cpu_rdata valid.
  - cycle 5: IDLE.
- Each wait cycle on grnt, arready or rvalid adds one cycle in its state.
- arvalid stays 1 until the handshake completes. The AR address and control outputs do not change while arvalid = 1.
- An rvalid that arrives while in ADDR is not accepted, because rready = 0 there.
- Back-to-back loads: the next access's need_read is sampled in IDLE, giving at least one idle cycle between transactions.

## Structure
- Shared package `axi_pkg` holds:
  - burst, size and lock encodings;
  - per-client ID constants (store 4'b0010, load 4'b0011);
  - the load-size enum.
- The lane-select and extension logic is a combinational sub-module, `load_extend`, with ports (rdata, addr[1:0], size, signed, out). It is reusable by the cached load path.
- The FSM, the registers and the AXI tie-offs live in `uncached_loader`.

## Test plan
- Word load at 0xBFAF_8000, with grnt, arready and rvalid immediate, rdata = 0x1234_5678.
  - Required: araddr = 0xBFAF_8000, arsize = 3'b010.
  - Required: cpu_stall high for exactly cycles 0–3, and cpu_rdata = 0x1234_5678 in cycle 4.
- Byte load, signed, addr[1:0] = 2'b11, rdata = 0x80xx_xxxx.
  - Required: cpu_rdata = 0xFFFF_FF80.
  - With cpu_signed = 0 the same access gives 0x0000_0080.
- Halfword load, unsigned, addr[1:0] = 2'b10, rdata = 0xBEEF_0000.
  - Required: cpu_rdata = 0x0000_BEEF, arsize = 3'b001.
- grnt delayed 3 cycles, arready delayed 2 cycles, and one R beat with rid = 4'b0010 before the matching beat.
  - Required: arvalid stays stable, the foreign beat is ignored, and DONE is reached only on the rid = 4'b0011 beat.
- rst_n low for one cycle while in DATA.
  - Required: the next cycle is IDLE with req, arvalid, rready and cpu_rdata all 0, and cpu_stall follows need_read.
- Cached load (cpu_uncached = 0).
  - Required: no req, cpu_stall = 0 throughout.
